// File: rtl/slc3_mem_responder_pkg.sv
// Shared types and defaults for the SLC-3 memory responder.
// SLC3_MEM_PARITY_EN adds a stored parity bit to each read-pipeline stage.
package slc3_mem_responder_pkg;

  localparam logic [15:0] SLC3_IO_ADDR = 16'hFFFF;
  localparam int unsigned SLC3_MEM_LAT = 2;
  localparam int unsigned DATA_W       = 16;

  typedef struct packed {
    logic              valid;
    logic              is_io;
`ifdef SLC3_MEM_PARITY_EN
    logic              par;
`endif
    logic [DATA_W-1:0] data;
  } rd_req_t;

endpackage

// File: rtl/slc3_mem_responder_if.sv
// SRAM request bus between the slc3 core (master) and the memory responder (slave).
interface slc3_mem_responder_if;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_mem_ena;
  logic        sram_wr_ena;
  logic [15:0] sram_rdata;
  logic        rdata_valid_o;

  modport master (
    output sram_addr, sram_wdata, sram_mem_ena, sram_wr_ena,
    input  sram_rdata, rdata_valid_o
  );

  modport slave (
    input  sram_addr, sram_wdata, sram_mem_ena, sram_wr_ena,
    output sram_rdata, rdata_valid_o
  );
endinterface

// File: rtl/slc3_rd_pipe.sv
// Fixed-latency read pipeline: carries sampled read data to sram_rdata/rdata_valid.
// With SLC3_MEM_PARITY_EN, perr_c flags a parity mismatch on the completing stage.
module slc3_rd_pipe
  import slc3_mem_responder_pkg::*;
#(
  parameter int unsigned READ_LATENCY = SLC3_MEM_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  rd_req_t           req,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy
`ifdef SLC3_MEM_PARITY_EN
  ,
  output logic              perr_c
`endif
);

  rd_req_t stg [READ_LATENCY];
  logic    busy_nxt;

  // Busy next cycle if anything will still occupy a stage after this edge.
  always_comb begin
    busy_nxt = req.valid;
    for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) begin
      busy_nxt = busy_nxt | stg[i].valid;
    end
  end

`ifdef SLC3_MEM_PARITY_EN
  assign perr_c = stg[READ_LATENCY-1].valid & ~stg[READ_LATENCY-1].is_io &
                  ((^stg[READ_LATENCY-1].data) ^ stg[READ_LATENCY-1].par);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        stg[i] <= '0;
      end
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      stg[0] <= req;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        stg[i] <= stg[i-1];
      end
      rdata_valid <= stg[READ_LATENCY-1].valid;
      if (stg[READ_LATENCY-1].valid) begin
        rdata <= stg[READ_LATENCY-1].data;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: word storage plus one I/O word (switches in, LEDs out).
// Optional SLC3_MEM_PARITY_EN: 17-bit storage with sticky parity_err_o.
module slc3_mem_responder
  import slc3_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = SLC3_MEM_LAT,
  parameter logic [15:0] IO_ADDR      = SLC3_IO_ADDR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  slc3_mem_responder_if.slave  bus,
  input  logic [DATA_W-1:0]    sw_i,
  output logic [DATA_W-1:0]    io_out_o,
  output logic                 busy_o
`ifdef SLC3_MEM_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef SLC3_MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              is_io;
  logic              wr_mem;
  logic              wr_io;
  rd_req_t           req;

  // Upper address bits are dropped, so storage aliases modulo DEPTH.
  assign idx    = bus.sram_addr[ADDR_W-1:0];
  assign is_io  = (bus.sram_addr == IO_ADDR);
  assign wr_mem = bus.sram_mem_ena & bus.sram_wr_ena & ~is_io;
  assign wr_io  = bus.sram_mem_ena & bus.sram_wr_ena & is_io;

  always_ff @(posedge clk) begin
    if (wr_mem) begin
`ifdef SLC3_MEM_PARITY_EN
      mem[idx] <= {^bus.sram_wdata, bus.sram_wdata};
`else
      mem[idx] <= bus.sram_wdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_out_o <= '0;
    end else if (wr_io) begin
      io_out_o <= bus.sram_wdata;
    end
  end

  // Read source is sampled at the accept edge.
  always_comb begin
    req       = '0;
    req.valid = bus.sram_mem_ena & ~bus.sram_wr_ena;
    req.is_io = is_io;
    if (is_io) begin
      req.data = sw_i;
    end else begin
      req.data = mem[idx][DATA_W-1:0];
    end
`ifdef SLC3_MEM_PARITY_EN
    req.par = is_io ? (^sw_i) : mem[idx][MEM_W-1];
`endif
  end

`ifdef SLC3_MEM_PARITY_EN
  logic perr_c;
`endif

  slc3_rd_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .rdata        (bus.sram_rdata),
    .rdata_valid  (bus.rdata_valid_o),
    .busy         (busy_o)
`ifdef SLC3_MEM_PARITY_EN
    ,
    .perr_c       (perr_c)
`endif
  );

`ifdef SLC3_MEM_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_o <= 1'b0;
    end else if (perr_c) begin
      parity_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Randomised scoreboard bench for slc3_mem_responder (ADDR_W=10, READ_LATENCY=2).
module tb_slc3_mem_responder;

  localparam int          LAT = 2;
  localparam logic [15:0] IO  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sw_i;
  logic [15:0] io_out_o;
  logic        busy_o;
`ifdef SLC3_MEM_PARITY_EN
  logic        parity_err_o;
`endif

  slc3_mem_responder_if bus ();

  slc3_mem_responder #(
    .ADDR_W       (10),
    .READ_LATENCY (LAT),
    .IO_ADDR      (IO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .sw_i         (sw_i),
    .io_out_o     (io_out_o),
    .busy_o       (busy_o)
`ifdef SLC3_MEM_PARITY_EN
    ,
    .parity_err_o (parity_err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    int          accept;
    int          due;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  logic [15:0] m_mem [1024];
  bit          m_ok  [1024];
  logic [15:0] m_io;
  logic [15:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: pops the scoreboard whenever a read completes, checks hold/busy otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit   exp_busy;
      if (bus.rdata_valid_o) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'(bus.rdata_valid_o), 32'd0);
        end else begin
          e = q.pop_front();
          check("rdata", 32'(bus.sram_rdata), 32'(e.data));
          check("latency", 32'(cyc), 32'(e.due));
          m_last = e.data;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          check("missing_valid", 32'(bus.rdata_valid_o), 32'd1);
          void'(q.pop_front());
        end
        check("rdata_hold", 32'(bus.sram_rdata), 32'(m_last));
      end
      exp_busy = 1'b0;
      foreach (q[i]) if (q[i].accept <= cyc) exp_busy = 1'b1;
      check("busy", 32'(busy_o), 32'(exp_busy));
    end
  end

  // One request cycle; the reference model reacts as of the upcoming accept edge.
  task automatic req(input bit ena, input bit wr, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [15:0] sw);
    exp_t e;
    @(negedge clk);
    check("io_out", 32'(io_out_o), 32'(m_io));
    bus.sram_mem_ena = ena;
    bus.sram_wr_ena  = wr;
    bus.sram_addr    = addr;
    bus.sram_wdata   = wd;
    sw_i             = sw;
    if (ena) begin
      if (wr) begin
        if (addr == IO) m_io = wd;
        else begin
          m_mem[addr % 1024] = wd;
          m_ok[addr % 1024]  = 1'b1;
        end
      end else begin
        e.accept = cyc + 1;
        e.due    = cyc + 1 + LAT;
        e.data   = (addr == IO) ? sw : m_mem[addr % 1024];
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 16'h0);
  endtask

  initial begin
    logic [15:0] a;
    int          op;
    reset_n          = 1'b0;
    bus.sram_mem_ena = 1'b0;
    bus.sram_wr_ena  = 1'b0;
    bus.sram_addr    = '0;
    bus.sram_wdata   = '0;
    sw_i             = '0;
    m_io             = '0;
    m_last           = '0;
    repeat (2) @(negedge clk);
    check("rst_rdata", 32'(bus.sram_rdata), 32'd0);
    check("rst_valid", 32'(bus.rdata_valid_o), 32'd0);
    check("rst_io_out", 32'(io_out_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Write then immediate read-back.
    req(1, 1, 16'h0005, 16'hBEEF, 16'h0);
    req(1, 0, 16'h0005, 16'h0, 16'h0);
    idle(LAT + 1);
    // Aliasing and I/O store leaving storage[3FF] intact.
    req(1, 1, 16'h03FF, 16'h7777, 16'h0);
    req(1, 1, 16'h0405, 16'h1234, 16'h0);
    req(1, 0, 16'h0005, 16'h0, 16'h0);
    req(1, 1, IO, 16'h00A5, 16'h0);
    req(1, 0, 16'h03FF, 16'h0, 16'h0);
    idle(LAT + 1);
    // Switch value sampled at accept.
    req(1, 0, IO, 16'h0, 16'h5A5A);
    req(0, 0, 16'h0, 16'h0, 16'h0000);
    idle(LAT + 1);
    // Back-to-back reads.
    req(1, 1, 16'h0001, 16'h0011, 16'h0);
    req(1, 1, 16'h0002, 16'h0022, 16'h0);
    req(1, 1, 16'h0003, 16'h0033, 16'h0);
    req(1, 0, 16'h0001, 16'h0, 16'h0);
    req(1, 0, 16'h0002, 16'h0, 16'h0);
    req(1, 0, 16'h0003, 16'h0, 16'h0);
    idle(LAT + 1);
    // Write behind an in-flight read.
    req(1, 1, 16'h0007, 16'hAAAA, 16'h0);
    req(1, 0, 16'h0007, 16'h0, 16'h0);
    req(1, 1, 16'h0007, 16'h5555, 16'h0);
    req(1, 0, 16'h0007, 16'h0, 16'h0);
    idle(LAT + 1);

    // Reset one cycle after a read accept drops the read.
    req(1, 0, 16'h0005, 16'h0, 16'h0);
    @(negedge clk);
    mon_en           = 1'b0;
    bus.sram_mem_ena = 1'b0;
    reset_n          = 1'b0;
    q.delete();
    m_last = '0;
    m_io   = '0;
    #1;
    check("midrst_rdata", 32'(bus.sram_rdata), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(bus.rdata_valid_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    idle(LAT + 2);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) a = IO;
      else a = 16'($urandom_range(0, 31)) | 16'(16'($urandom_range(0, 63)) << 10);
      op = int'($urandom_range(0, 9));
      if (op >= 5 && a != IO && !m_ok[a % 1024]) op = 2;
      if (op < 2)      req(0, 1'($urandom), a, 16'($urandom), 16'($urandom));
      else if (op < 5) req(1, 1, a, 16'($urandom), 16'($urandom));
      else             req(1, 0, a, 16'($urandom), 16'($urandom));
    end
    idle(LAT + 2);

`ifdef SLC3_MEM_PARITY_EN
    check("parity_clean", 32'(parity_err_o), 32'd0);
    req(1, 1, 16'h0009, 16'h0F0F, 16'h0);
    @(negedge clk);
    bus.sram_mem_ena = 1'b0;
    dut.mem[9]       = dut.mem[9] ^ 17'h1;
    m_mem[9]         = 16'h0F0E;
    req(1, 0, 16'h0009, 16'h0, 16'h0);
    idle(LAT + 1);
    check("parity_set", 32'(parity_err_o), 32'd1);
    req(1, 0, IO, 16'h0, 16'h1234);
    idle(LAT + 1);
    check("parity_sticky", 32'(parity_err_o), 32'd1);
`endif

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
